// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port RAM arbiter between a CPU port and a host/debug loader port
// Three-cycle access (sample, RAM strobe, ack); CPU wins contention until the host has lost STARVE_LIMIT times.
module ram_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,

    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,

    output logic [1:0]        owner
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_HOST = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CPU_ACC,
        S_HOST_ACC,
        S_ACK
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    starve_q, starve_d;
    logic [1:0]          owner_q, owner_d;
    logic                ram_cs_q, ram_cs_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                host_ack_q, host_ack_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
    logic                host_wins;

    // The RAM strobe registers double as the latched request: loaded on ACC
    // entry, cleared on every other transition so the bus idles at zero.
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        owner_d      = owner_q;
        ram_cs_d     = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = '0;
        ram_wdata_d  = '0;
        cpu_ack_d    = 1'b0;
        host_ack_d   = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        host_rdata_d = host_rdata_q;
        host_wins    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req || host_req) begin
                    host_wins = host_req && (!cpu_req || (starve_q == LIMIT));
                    ram_cs_d  = 1'b1;
                    if (host_wins) begin
                        state_d     = S_HOST_ACC;
                        starve_d    = '0;
                        owner_d     = OWN_HOST;
                        ram_we_d    = host_we;
                        ram_addr_d  = host_addr;
                        ram_wdata_d = host_wdata;
                    end else begin
                        state_d     = S_CPU_ACC;
                        owner_d     = OWN_CPU;
                        ram_we_d    = cpu_we;
                        ram_addr_d  = cpu_addr;
                        ram_wdata_d = cpu_wdata;
                        if (host_req && (starve_q != LIMIT)) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end
                end
            end
            S_CPU_ACC: begin
                state_d   = S_ACK;
                cpu_ack_d = 1'b1;
                if (!ram_we_q) begin
                    cpu_rdata_d = ram_rdata;
                end
            end
            S_HOST_ACC: begin
                state_d    = S_ACK;
                host_ack_d = 1'b1;
                if (!ram_we_q) begin
                    host_rdata_d = ram_rdata;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            starve_q     <= '0;
            owner_q      <= OWN_NONE;
            ram_cs_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            owner_q      <= owner_d;
            ram_cs_q     <= ram_cs_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            cpu_ack_q    <= cpu_ack_d;
            host_ack_q   <= host_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign host_rdata = host_rdata_q;
    assign host_ack   = host_ack_q;
    assign ram_cs     = ram_cs_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign owner      = owner_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter
// A transaction-level model predicts each grant; a monitor checks RAM strobes and acks against it.
module tb_ram_arbiter;

    localparam int AW  = 12;
    localparam int DW  = 4;
    localparam int LIM = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, host_req, host_we;
    logic [AW-1:0] cpu_addr, host_addr;
    logic [DW-1:0] cpu_wdata, host_wdata;
    logic [DW-1:0] cpu_rdata, host_rdata;
    logic          cpu_ack, host_ack;
    logic          ram_cs, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [1:0]    owner;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_ack(host_ack),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .owner(owner)
    );

    typedef struct packed {
        logic          host;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            cyc;
    } exp_t;

    exp_t  exp_q[$];
    bit    grant_log[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_pass = 0;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == 12'h010) return 4'h2;
        if (a == 12'h200) return 4'h3;
        return 4'(a * 13 + 5) ^ a[7:4];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] pack_log();
        logic [31:0] v = 0;
        foreach (grant_log[i]) v = (v << 1) | 32'(grant_log[i]);
        return v;
    endfunction

    // Environment RAM: combinational read, write on the clock edge while strobed.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    assign ram_rdata = mem[ram_addr];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = init_val(AW'(i));
        forever begin
            @(posedge clk);
            if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
        end
    end

    // Reference model: one grant per three cycles, contention decided by a loss counter.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    initial begin
        exp_t          e;
        exp_t          pend;
        int            slot;
        int            starve;
        logic [DW-1:0] last_c, last_h;
        slot = 0; starve = 0; last_c = '0; last_h = '0; pend = '0;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(AW'(i));
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                exp_q.delete();
                slot = 0; starve = 0; last_c = '0; last_h = '0;
            end else begin
                if (slot > 0) begin
                    if (slot == 2 && pend.we) ref_mem[pend.addr] = pend.wdata;
                    slot--;
                end else if (cpu_req || host_req) begin
                    e.host = host_req && (!cpu_req || starve == LIM);
                    if (e.host) starve = 0;
                    else if (host_req) starve++;
                    e.we    = e.host ? host_we    : cpu_we;
                    e.addr  = e.host ? host_addr  : cpu_addr;
                    e.wdata = e.host ? host_wdata : cpu_wdata;
                    if (!e.we) begin
                        e.rdata = ref_mem[e.addr];
                        if (e.host) last_h = e.rdata; else last_c = e.rdata;
                    end else begin
                        e.rdata = e.host ? last_h : last_c;
                    end
                    e.cyc = cyc;
                    exp_q.push_back(e);
                    pend = e;
                    slot = 2;
                end
                cyc++;
            end
        end
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("ack_exclusive", 32'(cpu_ack && host_ack), 0);
                check("we_without_cs", 32'(ram_we && !ram_cs), 0);
                if (ram_cs) begin
                    if (exp_q.size() == 0) check("unexpected_access", 1, 0);
                    else begin
                        e = exp_q[0];
                        check("access_cycle", 32'(cyc), 32'(e.cyc + 1));
                        check("ram_we", 32'(ram_we), 32'(e.we));
                        check("ram_addr", 32'(ram_addr), 32'(e.addr));
                        check("ram_wdata", 32'(ram_wdata), 32'(e.wdata));
                        check("owner_acc", 32'(owner), e.host ? 2 : 1);
                    end
                end
                if (cpu_ack || host_ack) begin
                    if (exp_q.size() == 0) check("unexpected_ack", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("ack_port", 32'(host_ack), 32'(e.host));
                        check("ack_cycle", 32'(cyc), 32'(e.cyc + 2));
                        check(e.host ? "host_rdata" : "cpu_rdata",
                              32'(e.host ? host_rdata : cpu_rdata), 32'(e.rdata));
                        check("owner_ack", 32'(owner), e.host ? 2 : 1);
                        grant_log.push_back(e.host);
                    end
                end
                if (!ram_cs && !cpu_ack && !host_ack) check("owner_idle", 32'(owner), 0);
            end
        end
    end

    task automatic port_access(input bit host, input bit we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wd, input bit keep);
        bit done = 0;
        if (host) begin
            host_req = 1; host_we = we; host_addr = addr; host_wdata = wd;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (host ? host_ack : cpu_ack) done = 1;
        end
        check(host ? "host_ack_seen" : "cpu_ack_seen", 32'(done), 1);
        @(posedge clk);
        #1;
        if (!keep) begin
            if (host) begin host_req = 0; host_we = 0; end
            else begin cpu_req = 0; cpu_we = 0; end
        end
    endtask

    task automatic wait_cs(output bit ok);
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (ram_cs) ok = 1;
        end
        check("ram_cs_seen", 32'(ok), 1);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        bit ok;
        reset = 1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", 32'({ram_cs, ram_we, ram_addr, ram_wdata, owner,
                                    cpu_ack, host_ack, cpu_rdata, host_rdata}), 0);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;

        // CPU write then read back
        port_access(0, 1, 12'h123, 4'hA, 0);
        port_access(0, 0, 12'h123, 4'h0, 0);
        check("cpu_read_0x123", 32'(cpu_rdata), 32'hA);

        // Host write, CPU reads it
        port_access(1, 1, 12'hFFF, 4'h5, 0);
        port_access(0, 0, 12'hFFF, 4'h0, 0);
        check("cpu_read_0xfff", 32'(cpu_rdata), 32'h5);

        // Host read, then host write leaves host_rdata alone
        port_access(1, 0, 12'h200, 4'h0, 0);
        check("host_read_0x200", 32'(host_rdata), 32'h3);
        port_access(1, 1, 12'h200, 4'h9, 0);
        check("host_rdata_after_write", 32'(host_rdata), 32'h3);

        // Host request arriving mid-access waits for the next IDLE
        grant_log.delete();
        fork
            port_access(0, 0, 12'h040, 4'h1, 0);
            begin
                wait_cs(ok);
                if (ok) port_access(1, 0, 12'h123, 4'h0, 0);
            end
        join
        check("late_host_count", 32'(grant_log.size()), 2);
        check("late_host_order", pack_log(), 32'b01);

        // Sustained contention: C,C,C,H,C,C,C,H
        grant_log.delete();
        fork
            for (int i = 0; i < 6; i++)
                port_access(0, 1'($urandom_range(0, 1)), 12'(12'h020 + i), 4'($urandom_range(0, 15)), i < 5);
            for (int i = 0; i < 2; i++)
                port_access(1, 1'($urandom_range(0, 1)), 12'(12'h030 + i), 4'($urandom_range(0, 15)), i < 1);
        join
        check("starve_count", 32'(grant_log.size()), 8);
        check("starve_order", pack_log(), 32'h11);

        // Reset aborts an in-flight CPU write
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h010; cpu_wdata = 4'h7;
        wait_cs(ok);
        reset = 1;
        cpu_req = 0; cpu_we = 0;
        #1;
        check("abort_outputs", 32'({ram_cs, ram_we, ram_addr, ram_wdata, owner,
                                    cpu_ack, host_ack, cpu_rdata, host_rdata}), 0);
        @(negedge clk);
        check("abort_no_ack", 32'(cpu_ack), 0);
        reset = 0;
        @(posedge clk);
        #1;
        port_access(1, 0, 12'h010, 4'h0, 0);
        check("abort_no_write", 32'(host_rdata), 32'h2);

        // Randomized traffic on both ports
        fork
            begin
                int gap;
                for (int i = 0; i < 40; i++) begin
                    gap = $urandom_range(0, 2);
                    port_access(0, 1'($urandom_range(0, 1)), 12'(12'h020 + $urandom_range(0, 15)),
                                4'($urandom_range(0, 15)), gap == 0);
                    repeat (gap) begin @(posedge clk); #1; end
                end
                cpu_req = 0;
            end
            begin
                int gap;
                for (int i = 0; i < 40; i++) begin
                    gap = $urandom_range(0, 3);
                    port_access(1, 1'($urandom_range(0, 1)), 12'(12'h020 + $urandom_range(0, 15)),
                                4'($urandom_range(0, 15)), gap == 0);
                    repeat (gap) begin @(posedge clk); #1; end
                end
                host_req = 0;
            end
        join

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
